// File: rtl/keysched_pkg.sv
// Shared types and defaults for the key schedule sequencer and its round-constant LFSR.
package keysched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    LOAD,
    RUN,
    DONE
  } ksc_state_t;

  localparam int KEY_WORDS = 4;

  localparam logic [9:0] DEF_C_SEED = 10'h001;
  localparam logic [9:0] DEF_C_POLY = 10'h240;  // x^10 + x^7 + 1

endpackage

// File: rtl/key_schedule_ctrl_rc_lfsr.sv
// Galois LFSR producing the round constants fed to the generator's k input.
module rc_lfsr #(
  parameter int                DATAW  = 10,
  parameter logic [DATAW-1:0]  C_POLY = DATAW'(10'h240)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [DATAW-1:0] seed,
  input  logic             adv,
  output logic [DATAW-1:0] state
);

  logic [DATAW-1:0] state_q;
  logic [DATAW-1:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = seed;
    end else if (adv) begin
      state_d = state_q[0] ? ((state_q >> 1) ^ C_POLY) : (state_q >> 1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= seed;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/key_schedule_ctrl.sv
// Key schedule sequencer: buffers a 4-word master key, replays it into keydegen, then feeds round constants.
// Optional abort input is compiled in when KSC_ABORT_EN is defined.
module key_schedule_ctrl
  import keysched_pkg::*;
#(
  parameter int               DATAW   = 10,
  parameter int               NROUNDS = 32,
  parameter logic [DATAW-1:0] C_SEED  = DATAW'(DEF_C_SEED),
  parameter logic [DATAW-1:0] C_POLY  = DATAW'(DEF_C_POLY),
  localparam int              IDXW    = $clog2(NROUNDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DATAW-1:0] key_in,
  input  logic             key_valid,
  output logic             key_ready,
  output logic [DATAW-1:0] kd_key,
  output logic             kd_kctr,
  output logic [DATAW-1:0] kd_k,
  output logic             rk_valid,
  output logic [IDXW-1:0]  rk_idx,
  output logic             busy,
  output logic             done
`ifdef KSC_ABORT_EN
  ,
  input  logic             abort
`endif
);

  localparam logic [IDXW-1:0] LAST_WORD = IDXW'(KEY_WORDS - 1);
  localparam logic [IDXW-1:0] RUN_LAST  = IDXW'(NROUNDS - 5);

  logic abort_i;
`ifdef KSC_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  ksc_state_t state_q, state_d;
  logic [IDXW-1:0]  cnt_q, cnt_d;
  logic             key_ready_q, key_ready_d;
  logic [DATAW-1:0] kd_key_q, kd_key_d;
  logic             kd_kctr_q, kd_kctr_d;
  logic [DATAW-1:0] kd_k_q, kd_k_d;
  logic             rk_valid_q, rk_valid_d;
  logic [IDXW-1:0]  rk_idx_q, rk_idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [DATAW-1:0] key_buf_q [KEY_WORDS];
  logic             wr_en;
  logic [1:0]       load_sel;
  logic             lfsr_load;
  logic             lfsr_adv;
  logic [DATAW-1:0] lfsr_state;

  rc_lfsr #(
    .DATAW  (DATAW),
    .C_POLY (C_POLY)
  ) u_rc_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .seed  (C_SEED),
    .adv   (lfsr_adv),
    .state (lfsr_state)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en     = 1'b0;
    lfsr_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort_i) begin
          state_d = FILL;
          cnt_d   = '0;
        end
      end
      FILL: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (key_valid && key_ready_q) begin
          wr_en = 1'b1;
          if (cnt_q == LAST_WORD) begin
            state_d   = LOAD;
            cnt_d     = '0;
            lfsr_load = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      LOAD: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (cnt_q == LAST_WORD) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (cnt_q == RUN_LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    load_sel    = (state_q == LOAD) ? (cnt_q[1:0] + 2'd1) : 2'd0;
    lfsr_adv    = (state_d == RUN);
    key_ready_d = (state_d == FILL);
    busy_d      = (state_d != IDLE);
    kd_kctr_d   = (state_d == LOAD);
    kd_key_d    = (state_d == LOAD) ? key_buf_q[load_sel] : '0;
    kd_k_d      = (state_d == RUN) ? lfsr_state : '0;
    done_d      = (state_d == DONE);
    rk_valid_d  = ((state_q == LOAD) || (state_q == RUN)) && !abort_i;
    rk_idx_d    = '0;
    if (rk_valid_d && rk_valid_q) begin
      rk_idx_d = rk_idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      key_buf_q[cnt_q[1:0]] <= key_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      key_ready_q <= 1'b0;
      kd_key_q    <= '0;
      kd_kctr_q   <= 1'b0;
      kd_k_q      <= '0;
      rk_valid_q  <= 1'b0;
      rk_idx_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_ready_q <= key_ready_d;
      kd_key_q    <= kd_key_d;
      kd_kctr_q   <= kd_kctr_d;
      kd_k_q      <= kd_k_d;
      rk_valid_q  <= rk_valid_d;
      rk_idx_q    <= rk_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign key_ready = key_ready_q;
  assign kd_key    = kd_key_q;
  assign kd_kctr   = kd_kctr_q;
  assign kd_k      = kd_k_q;
  assign rk_valid  = rk_valid_q;
  assign rk_idx    = rk_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Scoreboard bench for key_schedule_ctrl: expected per-cycle generator drive pushed when the 4th key word is accepted.
module tb_key_schedule_ctrl;

  localparam int DATAW   = 10;
  localparam int NROUNDS = 32;
  localparam int IDXW    = $clog2(NROUNDS);
  localparam logic [DATAW-1:0] SEED = 10'h001;
  localparam logic [DATAW-1:0] POLY = 10'h240;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             key_valid = 1'b0;
  logic [DATAW-1:0] key_in = '0;
  logic             key_ready;
  logic [DATAW-1:0] kd_key;
  logic             kd_kctr;
  logic [DATAW-1:0] kd_k;
  logic             rk_valid;
  logic [IDXW-1:0]  rk_idx;
  logic             busy;
  logic             done;
  logic             abort_s;
`ifdef KSC_ABORT_EN
  logic             abort = 1'b0;
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  always #5 clk = ~clk;

  key_schedule_ctrl #(
    .DATAW   (DATAW),
    .NROUNDS (NROUNDS),
    .C_SEED  (SEED),
    .C_POLY  (POLY)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .kd_key    (kd_key),
    .kd_kctr   (kd_kctr),
    .kd_k      (kd_k),
    .rk_valid  (rk_valid),
    .rk_idx    (rk_idx),
    .busy      (busy),
    .done      (done)
`ifdef KSC_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  typedef struct {
    logic             kctr;
    logic [DATAW-1:0] key;
    logic             kchk;
    logic [DATAW-1:0] k;
    logic             rkv;
    logic [IDXW-1:0]  idx;
    logic             dn;
    int               kk;
  } item_t;

  item_t            sb[$];
  int               errors = 0;
  int               checks = 0;
  int               m_state = 0;   // 0 idle, 1 fill, 2 scheduled replay/run
  int               m_cnt = 0;
  logic [DATAW-1:0] m_words [4];
  bit               expect_rst = 1'b0;
  int               cur_k = 0;
  logic [DATAW-1:0] kw_a [4];
  logic [DATAW-1:0] kw_b [4];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATAW-1:0] lfsr_step(input logic [DATAW-1:0] s);
    return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  // Cycle t+k after the 4th word is accepted, k = 1..NROUNDS+1.
  task automatic push_sched();
    item_t            it;
    logic [DATAW-1:0] c;
    c = SEED;
    for (int k = 1; k <= NROUNDS + 1; k++) begin
      it.kk   = k;
      it.kctr = (k <= 4);
      it.key  = (k <= 4) ? m_words[k-1] : '0;
      it.kchk = (k >= 5) && (k <= NROUNDS);
      it.k    = it.kchk ? c : '0;
      if (it.kchk) c = lfsr_step(c);
      it.rkv  = (k >= 2);
      it.idx  = (k >= 2) ? IDXW'(k - 2) : '0;
      it.dn   = (k == NROUNDS + 1);
      sb.push_back(it);
    end
    cur_k = 0;
  endtask

  always @(negedge clk) begin
    item_t it;
    int    st;
    st = m_state;
    if (expect_rst) begin
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_rk_valid", 32'(rk_valid), 32'd0);
      check_eq("rst_kctr", 32'(kd_kctr), 32'd0);
      check_eq("rst_key_ready", 32'(key_ready), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_kd_key", 32'(kd_key), 32'd0);
      check_eq("rst_kd_k", 32'(kd_k), 32'd0);
      check_eq("rst_rk_idx", 32'(rk_idx), 32'd0);
    end else if (st == 2) begin
      check_eq("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        it = sb.pop_front();
        cur_k = it.kk;
        check_eq($sformatf("kctr_k%0d", it.kk), 32'(kd_kctr), 32'(it.kctr));
        if (it.kctr) check_eq($sformatf("kd_key_k%0d", it.kk), 32'(kd_key), 32'(it.key));
        if (it.kchk) check_eq($sformatf("kd_k_k%0d", it.kk), 32'(kd_k), 32'(it.k));
        check_eq($sformatf("rk_valid_k%0d", it.kk), 32'(rk_valid), 32'(it.rkv));
        if (it.rkv) check_eq($sformatf("rk_idx_k%0d", it.kk), 32'(rk_idx), 32'(it.idx));
        check_eq($sformatf("done_k%0d", it.kk), 32'(done), 32'(it.dn));
        check_eq($sformatf("busy_k%0d", it.kk), 32'(busy), 32'd1);
        check_eq($sformatf("key_ready_k%0d", it.kk), 32'(key_ready), 32'd0);
        if (it.dn) begin
          m_state = 0;
          $display("schedule complete: words %h %h %h %h, last rk_idx=%0d", m_words[0], m_words[1],
                   m_words[2], m_words[3], rk_idx);
        end
      end else begin
        m_state = 0;
      end
    end else begin
      check_eq("idle_busy", 32'(busy), 32'(st == 1));
      check_eq("idle_key_ready", 32'(key_ready), 32'(st == 1));
      check_eq("idle_kctr", 32'(kd_kctr), 32'd0);
      check_eq("idle_rk_valid", 32'(rk_valid), 32'd0);
      check_eq("idle_done", 32'(done), 32'd0);
    end
    expect_rst = 1'b0;

    if (reset) begin
      sb.delete();
      m_state    = 0;
      expect_rst = 1'b1;
    end else if (abort_s && (st == 1 || (st == 2 && m_state == 2))) begin
      sb.delete();
      m_state = 0;
    end else if (st == 0) begin
      if (start && !abort_s) begin
        m_state = 1;
        m_cnt   = 0;
      end
    end else if (st == 1) begin
      if (key_valid) begin
        m_words[m_cnt] = key_in;
        m_cnt++;
        if (m_cnt == 4) begin
          push_sched();
          m_state = 2;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_k(input int target);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (cur_k >= target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check_eq("wait_run_cycle", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (m_state == 0 && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check_eq("wait_idle", 32'(ok), 32'd1);
    tick();
  endtask

  // mode: 0 plain, 1 start pulse during RUN, 2 reset during RUN, 3 abort in 3rd RUN cycle
  task automatic run_sched(input logic [DATAW-1:0] w [4], input logic [7:0] pat, input int npat,
                           input bit hold_valid, input int mode);
    int idx;
    idx   = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < npat && idx < 4; i++) begin
      key_valid = pat[i];
      key_in    = pat[i] ? w[idx] : 10'h3ff;
      if (pat[i]) idx++;
      tick();
    end
    key_valid = hold_valid;
    key_in    = 10'h155;
    if (hold_valid) begin
      repeat (5) tick();
      key_valid = 1'b0;
    end
    case (mode)
      1: begin
        wait_k(6);
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      2: begin
        wait_k(8);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
      end
`ifdef KSC_ABORT_EN
      3: begin
        wait_k(6);
        abort = 1'b1;
        tick();
        abort = 1'b0;
      end
`endif
      default: ;
    endcase
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    kw_a[0] = 10'h001; kw_a[1] = 10'h002; kw_a[2] = 10'h003; kw_a[3] = 10'h004;
    kw_b[0] = 10'h2a5; kw_b[1] = 10'h15a; kw_b[2] = 10'h3c3; kw_b[3] = 10'h07e;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    run_sched(kw_a, 8'b0000_1111, 4, 1'b0, 0);
    run_sched(kw_b, 8'b0101_1001, 7, 1'b0, 0);
    run_sched(kw_a, 8'b0000_1111, 4, 1'b1, 1);
    run_sched(kw_b, 8'b0000_1111, 4, 1'b0, 2);
    run_sched(kw_a, 8'b0000_1111, 4, 1'b0, 0);
`ifdef KSC_ABORT_EN
    run_sched(kw_b, 8'b0000_1111, 4, 1'b0, 3);
    run_sched(kw_a, 8'b0000_1111, 4, 1'b0, 0);
`endif
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
